// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM states and next-PC source select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by importers: PC_GEN_RVC_EN (16-bit compressed instructions).
package pc_gen_pkg;

   // Controller states; BOOT lasts exactly one cycle after reset unless a trap/redirect moves on first.
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pcState_t;

   // Source of the next PC value, listed in decreasing priority.
   typedef enum logic [1:0] {
      TRAP     = 2'd0,
      REDIRECT = 2'd1,
      HOLD     = 2'd2,
      SEQ      = 2'd3
   } pcSel_t;

   // Instruction-size increments.
   localparam int INCR_STD = 4;
   localparam int INCR_RVC = 2;

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder: pcNext = pcCur + instruction size, wrapping modulo 2^XLEN.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: pcCur (current PC), isCompressed (16-bit instruction flag), pcNext (link / fall-through PC).
// Macro PC_GEN_RVC_EN: when defined, isCompressed selects a 2-byte step; otherwise it is ignored.
module pc_incr
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pcCur,
   input  logic            isCompressed,
   output logic [XLEN-1:0] pcNext
);

`ifdef PC_GEN_RVC_EN
   assign pcNext = pcCur + (isCompressed ? XLEN'(INCR_RVC) : XLEN'(INCR_STD));
`else
   // Port kept for a uniform interface; the flag has no effect in this build.
   logic unusedIsCompressed;
   assign unusedIsCompressed = isCompressed;
   assign pcNext = pcCur + XLEN'(INCR_STD);
`endif

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT controller choosing trap, redirect, hold or sequential PC.
// Latency: one cycle from request inputs to registered pc / misalign_err; pc_plus is combinational.
// Backpressure: fetch_ready=0 holds pc in RUN; trap and redirect are taken regardless of fetch_ready.
// Ports: clk, rst (async active-high); fetch_ready, redirect_valid/redirect_target, trap_valid,
//   halt_req, resume, is_compressed in; pc, pc_valid, pc_plus, misalign_err out.
// Macro PC_GEN_RVC_EN: 2-byte alignment and 2-byte steps for compressed instructions.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            is_compressed,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic [XLEN-1:0] pc_plus,
   output logic            misalign_err
);

   // Low address bits that must be zero for a legal instruction address.
`ifdef PC_GEN_RVC_EN
   localparam logic [XLEN-1:0] LOW_BITS = XLEN'(1);
`else
   localparam logic [XLEN-1:0] LOW_BITS = XLEN'(3);
`endif

   pcState_t        stateQ;
   pcState_t        stateNext;
   pcSel_t          pcSel;
   logic [XLEN-1:0] pcNext;
   logic [XLEN-1:0] redirectAligned;
   logic            misalignNext;

   pc_incr #(
      .XLEN(XLEN)
   ) u_pc_incr (
      .pcCur       (pc),
      .isCompressed(is_compressed),
      .pcNext      (pc_plus)
   );

   assign redirectAligned = redirect_target & ~LOW_BITS;
   // Flag only when the redirect is actually taken, i.e. not shadowed by a trap.
   assign misalignNext    = (pcSel == REDIRECT) && ((redirect_target & LOW_BITS) != '0);

   // State register (with the PC and the error pulse it qualifies).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ       <= BOOT;
         pc           <= RESET_VECTOR;
         misalign_err <= 1'b0;
      end else begin
         stateQ       <= stateNext;
         pc           <= pcNext;
         misalign_err <= misalignNext;
      end
   end

   // Next-state and next-PC selection, highest priority first.
   always_comb begin
      pcSel     = HOLD;
      stateNext = stateQ;
      if (trap_valid) begin
         pcSel     = TRAP;
         stateNext = RUN;
      end else if (redirect_valid) begin
         pcSel = REDIRECT;
         if (stateQ == BOOT) stateNext = RUN;
      end else if (halt_req) begin
         // BOOT always leaves after one cycle; a halt request there is not honoured.
         pcSel     = HOLD;
         stateNext = (stateQ == BOOT) ? RUN : HALT;
      end else begin
         case (stateQ)
            BOOT:    stateNext = RUN;
            RUN:     if (fetch_ready) pcSel = SEQ;
            HALT:    if (resume) stateNext = RUN;
            default: stateNext = BOOT;
         endcase
      end
   end

   always_comb begin
      pcNext = pc;
      case (pcSel)
         TRAP:     pcNext = TRAP_VECTOR;
         REDIRECT: pcNext = redirectAligned;
         SEQ:      pcNext = pc_plus;
         default:  pcNext = pc;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      pc_valid = (stateQ == RUN);
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC/address width in bits.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-003 SHALL provide parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on trap.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port fetch_ready, input, 1, fetch stage accepts the current PC this cycle.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_target, input, XLEN, redirect destination.
REQ-010 SHALL have port trap_valid, input, 1, trap request.
REQ-011 SHALL have port halt_req, input, 1, enter HALT.
REQ-012 SHALL have port resume, input, 1, leave HALT.
REQ-013 SHALL have port is_compressed, input, 1, current instruction is 16-bit.
REQ-014 SHALL have port pc, output, XLEN, registered current PC.
REQ-015 SHALL have port pc_valid, output, 1, pc is valid for fetch.
REQ-016 SHALL have port pc_plus, output, XLEN, combinational pc + increment, the link value.
REQ-017 SHALL have port misalign_err, output, 1, one-cycle registered pulse flagging a misaligned redirect.

Function
REQ-018 SHALL implement the states BOOT, RUN and HALT.
REQ-019 SHALL move BOOT to RUN after one cycle, unconditionally; pc_valid is 0 in BOOT, 1 in RUN and 0 in HALT.
REQ-020 SHALL evaluate next-PC in priority order: trap_valid, then redirect_valid, then halt_req, then sequential advance.
REQ-021 SHALL, on trap_valid, load pc=TRAP_VECTOR and enter RUN from any state, BOOT included.
REQ-022 SHALL, on redirect_valid, load the aligned redirect_target in RUN or HALT regardless of fetch_ready, with the state unchanged; in BOOT it loads the target and proceeds to RUN.
REQ-023 SHALL align by clearing bit[0] when PC_GEN_RVC_EN is defined, else bits[1:0]; misalign_err pulses the next cycle if any cleared bit was 1.
REQ-024 SHALL advance sequentially only in RUN with fetch_ready=1: pc <= pc_plus; with fetch_ready=0, pc holds.
REQ-025 SHALL, when halt_req=1 in RUN, hold pc, discard any sequential advance, and enter HALT next cycle.
REQ-026 SHALL, in HALT, return to RUN with pc unchanged on resume=1 and halt_req=0; halt_req=1 with resume=1 keeps HALT.
REQ-027 SHALL compute pc + increment modulo 2^XLEN, wrapping silently with no flag.

Reset
REQ-028 SHALL, while rst=1, asynchronously force pc=RESET_VECTOR, state=BOOT, pc_valid=0 and misalign_err=0.
REQ-029 SHALL, when reset asserts mid-operation, abandon any pending redirect, trap or halt; no state survives reset.

Configuration
REQ-030 SHALL, with macro PC_GEN_RVC_EN defined, use an increment of 2 when is_compressed=1 and 4 otherwise.
REQ-031 SHALL, without PC_GEN_RVC_EN, use an increment of always 4 and ignore is_compressed, while keeping the port.

Structure
REQ-032 SHALL place the state enum (BOOT/RUN/HALT) and the next-PC select enum (TRAP/REDIRECT/HOLD/SEQ) in shared package pc_gen_pkg.
REQ-033 SHALL instantiate one sub-module, pc_incr, a parametrised XLEN adder producing pc_plus.

Verification
REQ-034 SHALL cover: reset release -> pc=0x0, pc_valid=0 for 1 cycle, then pc_valid=1 with pc=0x0.
REQ-035 SHALL cover: RUN, fetch_ready=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; fetch_ready=0 -> pc holds 0xC.
REQ-036 SHALL cover: redirect_valid and trap_valid in the same cycle with target 0x200 -> pc=0x100; redirect 0x203 alone -> pc=0x200 (0x202 with RVC), misalign_err=1 for one cycle.
REQ-037 SHALL cover: halt_req at pc=0x10 -> HALT, pc_valid=0, pc stays 0x10; resume -> RUN at 0x10; trap during HALT -> RUN at 0x100.
REQ-038 SHALL cover: pc=0xFFFF_FFFC with advance -> pc=0x0000_0000 and no flag; with RVC and is_compressed=1 at 0x8 -> 0xA.
REQ-039 SHALL cover: rst asserted mid-cycle during pending redirect -> pc=0x0 immediately and state BOOT.
